encode_64b_66b: RTL and testbench

ENCODE_64B_66B -- requirements
Module: encode_64b_66b

---
 rtl/encode_64b_66b.sv | 196 +++++++++++++++++++
 tb/tb_encode_64b_66b.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_64b_66b.sv
// ============================================================================
// Module   : encode_64b_66b
// Function : XGMII Tx word to 64b/66b block encoder with Tx state machine
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encode_64b_66b #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [63:0]          xgmii_txd_i,
  input  logic [7:0]           xgmii_txc_i,
  input  logic                 xgmii_txd_vld_i,
  output logic [63:0]          encode_data_o,
  output logic [1:0]           encode_head_o,
  output logic                 encode_data_vld_o,
  output logic                 encode_error_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [1:0] TX_INIT = 2'd0;
  localparam logic [1:0] TX_C    = 2'd1;
  localparam logic [1:0] TX_D    = 2'd2;
  localparam logic [1:0] TX_E    = 2'd3;

  localparam logic [2:0] BLK_C = 3'd0;
  localparam logic [2:0] BLK_S = 3'd1;
  localparam logic [2:0] BLK_D = 3'd2;
  localparam logic [2:0] BLK_T = 3'd3;
  localparam logic [2:0] BLK_E = 3'd4;

  localparam logic [1:0]  c_HEAD_DATA = 2'b10;
  localparam logic [1:0]  c_HEAD_CTRL = 2'b01;
  localparam logic [7:0]  c_IDLE      = 8'h07;
  localparam logic [7:0]  c_START     = 8'hFB;
  localparam logic [7:0]  c_TERM      = 8'hFD;
  localparam logic [63:0] c_C_BLOCK   = {56'h0, 8'h1E};
  localparam logic [63:0] c_ERR_BLOCK = {{8{7'h1E}}, 8'h1E};
  // Block type bytes for T0..T7, T0 in the low byte
  localparam logic [63:0] c_T_TYPES   = {8'hFF, 8'hE1, 8'hD2, 8'hCC,
                                         8'hB4, 8'hAA, 8'h99, 8'h87};

  logic [7:0][7:0]  w_lane;
  logic [7:0]       w_lane_idle;
  logic [7:0]       w_is_t;
  logic [7:0][63:0] w_t_payload;
  logic             w_is_d;
  logic             w_is_c;
  logic             w_is_s0;
  logic             w_is_s4;
  logic             w_is_any_t;
  logic [63:0]      w_t_block;
  logic [2:0]       w_blk;

  logic [1:0]           state_q,  state_d;
  logic [63:0]          data_q,   data_d;
  logic [1:0]           head_q,   head_d;
  logic                 vld_q,    vld_d;
  logic                 err_q,    err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign w_lane = xgmii_txd_i;

  for (genvar j = 0; j < 8; j++) begin : g_lane
    assign w_lane_idle[j] = (w_lane[j] == c_IDLE);
  end

  // Tk: control flags on lanes k..7, terminate on lane k, idles above it
  for (genvar k = 0; k < 8; k++) begin : g_term
    localparam logic [7:0]  c_TXC_K   = 8'hFF << k;
    localparam logic [7:0]  c_ABOVE_K = 8'hFF << (k + 1);
    localparam logic [63:0] c_KEEP_K  = (k == 0) ? 64'h0 : ({64{1'b1}} >> (64 - 8 * k));

    assign w_is_t[k] = (xgmii_txc_i == c_TXC_K) &&
                       (w_lane[k] == c_TERM) &&
                       ((w_lane_idle & c_ABOVE_K) == c_ABOVE_K);
    assign w_t_payload[k] = ((xgmii_txd_i & c_KEEP_K) << 8) |
                            {56'h0, c_T_TYPES[8*k +: 8]};
  end

  assign w_is_d     = (xgmii_txc_i == 8'h00);
  assign w_is_c     = (xgmii_txc_i == 8'hFF) && (&w_lane_idle);
  assign w_is_s0    = (xgmii_txc_i == 8'h01) && (w_lane[0] == c_START);
  assign w_is_s4    = (xgmii_txc_i == 8'h1F) && (&w_lane_idle[3:0]) &&
                      (w_lane[4] == c_START);
  assign w_is_any_t = |w_is_t;

  always_comb begin
    w_t_block = 64'h0;
    for (int k = 0; k < 8; k++) begin
      if (w_is_t[k]) begin
        w_t_block = w_t_block | w_t_payload[k];
      end
    end
  end

  always_comb begin
    w_blk = BLK_E;
    case (state_q)
      TX_INIT, TX_C: begin
        if (w_is_c) begin
          w_blk = BLK_C;
        end else if (w_is_s0 || w_is_s4) begin
          w_blk = BLK_S;
        end
      end
      TX_D: begin
        if (w_is_d) begin
          w_blk = BLK_D;
        end else if (w_is_any_t) begin
          w_blk = BLK_T;
        end
      end
      default: begin
        if (w_is_c) begin
          w_blk = BLK_C;
        end else if (w_is_d) begin
          w_blk = BLK_D;
        end else if (w_is_any_t) begin
          w_blk = BLK_T;
        end
      end
    endcase
  end

  // Invalid cycles freeze everything except the output valid strobe
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    head_d    = head_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    vld_d     = xgmii_txd_vld_i;
    if (xgmii_txd_vld_i) begin
      err_d  = 1'b0;
      head_d = c_HEAD_CTRL;
      case (w_blk)
        BLK_D: begin
          head_d  = c_HEAD_DATA;
          data_d  = xgmii_txd_i;
          state_d = TX_D;
        end
        BLK_C: begin
          data_d  = c_C_BLOCK;
          state_d = TX_C;
        end
        BLK_S: begin
          data_d  = w_is_s0 ? {xgmii_txd_i[63:8], 8'h78}
                            : {xgmii_txd_i[63:40], 32'h0, 8'h33};
          state_d = TX_D;
        end
        BLK_T: begin
          data_d  = w_t_block;
          state_d = TX_C;
        end
        default: begin
          data_d  = c_ERR_BLOCK;
          state_d = TX_E;
          err_d   = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= TX_INIT;
      data_q    <= 64'h0;
      head_q    <= 2'b00;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      head_q    <= head_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign encode_data_o     = data_q;
  assign encode_head_o     = head_q;
  assign encode_data_vld_o = vld_q;
  assign encode_error_o    = err_q;
  assign err_cnt_o         = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_encode_64b_66b.sv
// Bench for encode_64b_66b: directed scenarios plus randomized words checked
// against a block-legality reference model.
`default_nettype none

module tb_encode_64b_66b;

  localparam int K_C = 0;
  localparam int K_S = 1;
  localparam int K_D = 2;
  localparam int K_T = 3;
  localparam int K_E = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] txd = 64'h0;
  logic [7:0]  txc = 8'h0;
  logic        vld = 1'b0;

  logic [63:0] o_data;
  logic [1:0]  o_head;
  logic        o_vld;
  logic        o_err;
  logic [15:0] o_cnt;

  logic [63:0] s_data;
  logic [1:0]  s_head;
  logic        s_vld;
  logic        s_err;
  logic [1:0]  s_cnt;

  logic [63:0] e_data;
  logic [1:0]  e_head;
  logic        e_vld;
  logic        e_err;
  logic [15:0] e_cnt;
  logic [1:0]  e_cnt2;
  int          m_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  encode_64b_66b dut (
    .clk_i(clk), .rst_n_i(rst_n), .xgmii_txd_i(txd), .xgmii_txc_i(txc),
    .xgmii_txd_vld_i(vld), .encode_data_o(o_data), .encode_head_o(o_head),
    .encode_data_vld_o(o_vld), .encode_error_o(o_err), .err_cnt_o(o_cnt)
  );

  encode_64b_66b #(.ERR_CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .xgmii_txd_i(txd), .xgmii_txc_i(txc),
    .xgmii_txd_vld_i(vld), .encode_data_o(s_data), .encode_head_o(s_head),
    .encode_data_vld_o(s_vld), .encode_error_o(s_err), .err_cnt_o(s_cnt)
  );

  task automatic model_reset();
    e_data = 64'h0; e_head = 2'b00; e_vld = 1'b0; e_err = 1'b0;
    e_cnt = 16'h0; e_cnt2 = 2'h0; m_last = K_C;
  endtask

  // Classify per lane rules, then decide legality from the last emitted block
  task automatic model_word(input logic [63:0] d, input logic [7:0] c);
    logic [7:0] ln [8];
    logic [7:0] tt [8];
    logic [7:0] want;
    bit all_idle, ok, legal;
    int cls, tk;
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    for (int j = 0; j < 8; j++) ln[j] = d[8*j +: 8];
    all_idle = 1;
    for (int j = 0; j < 8; j++) if (ln[j] != 8'h07) all_idle = 0;
    cls = K_E; tk = 0;
    if (c == 8'h00) cls = K_D;
    else if (c == 8'hFF && all_idle) cls = K_C;
    else if (c == 8'h01 && ln[0] == 8'hFB) cls = K_S;
    else if (c == 8'h1F && ln[0] == 8'h07 && ln[1] == 8'h07 && ln[2] == 8'h07 &&
             ln[3] == 8'h07 && ln[4] == 8'hFB) cls = K_S;
    else begin
      for (int k = 0; k < 8; k++) begin
        want = 8'hFF << k;
        ok = (c == want) && (ln[k] == 8'hFD);
        for (int j = k + 1; j < 8; j++) if (ln[j] != 8'h07) ok = 0;
        if (ok) begin cls = K_T; tk = k; end
      end
    end
    if (m_last == K_C || m_last == K_T) legal = (cls == K_C || cls == K_S);
    else if (m_last == K_S || m_last == K_D) legal = (cls == K_D || cls == K_T);
    else legal = (cls == K_C || cls == K_D || cls == K_T);
    if (!legal) cls = K_E;
    e_head = (cls == K_D) ? 2'b10 : 2'b01;
    e_err  = (cls == K_E);
    case (cls)
      K_D: e_data = d;
      K_C: e_data = {56'h0, 8'h1E};
      K_S: e_data = (c == 8'h01) ? {d[63:8], 8'h78} : {d[63:40], 32'h0, 8'h33};
      K_T: begin
        e_data = 64'h0;
        e_data[7:0] = tt[tk];
        for (int j = 0; j < tk; j++) e_data[8*j+8 +: 8] = ln[j];
      end
      default: begin
        e_data = {{8{7'h1E}}, 8'h1E};
        if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        if (e_cnt2 != 2'd3) e_cnt2 = e_cnt2 + 2'd1;
      end
    endcase
    m_last = cls;
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    txd = d; txc = c; vld = 1'b1;
    model_word(d, c);
    e_vld = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    vld = 1'b0; txd = {$urandom, $urandom}; txc = 8'($urandom);
    e_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vld = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic make_word(output logic [63:0] d, output logic [7:0] c);
    int sel, k;
    sel = $urandom_range(0, 9);
    d = {$urandom, $urandom};
    c = 8'h00;
    if (sel <= 3) c = 8'h00;
    else if (sel == 4) begin d = {8{8'h07}}; c = 8'hFF; end
    else if (sel == 5) begin d[7:0] = 8'hFB; c = 8'h01; end
    else if (sel == 6) begin d[39:0] = {8'hFB, 32'h07070707}; c = 8'h1F; end
    else if (sel <= 8) begin
      k = $urandom_range(0, 7);
      d[8*k +: 8] = 8'hFD;
      for (int j = k + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
      c = 8'hFF << k;
    end else c = 8'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (o_data !== 64'h0 || o_head !== 2'b00 || o_vld !== 1'b0 || o_err !== 1'b0 || o_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h head=%b vld=%b err=%b cnt=%0d, want all zero",
               o_data, o_head, o_vld, o_err, o_cnt);
    end
    n_cmp++;
    if (s_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_sat_cnt: got %0d want 0", s_cnt); end
  endtask

  task automatic test_frame();
    logic [63:0] words [5];
    logic [7:0]  ctls [5];
    logic [1:0]  heads [5];
    words = '{{8{8'h07}}, {{7{8'h55}}, 8'hFB}, 64'h0123456789ABCDEF,
              64'hFEDCBA9876543210, 64'h07070707_FD_332211};
    ctls  = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'hF8};
    heads = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_word(words[i], ctls[i]);
      n_cmp++;
      if (o_head !== heads[i] || o_data !== e_data || o_err !== 1'b0) begin
        n_bad++;
        $display("FAIL frame_word%0d: got head=%b data=%h err=%b, want head=%b data=%h err=0",
                 i, o_head, o_data, o_err, heads[i], e_data);
      end
    end
    n_cmp++;
    if (o_data !== {32'h0, 24'h332211, 8'hB4}) begin
      n_bad++; $display("FAIL frame_t3_payload: got %h want %h", o_data, {32'h0, 24'h332211, 8'hB4});
    end
  endtask

  task automatic test_error_first();
    do_reset();
    drive_word(64'h1122334455667788, 8'h00);
    n_cmp++;
    if (o_data !== {{8{7'h1E}}, 8'h1E} || o_head !== 2'b01 || o_err !== 1'b1 || o_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL error_first: got data=%h head=%b err=%b cnt=%0d, want error block, err=1 cnt=1",
               o_data, o_head, o_err, o_cnt);
    end
    drive_word({8{8'h07}}, 8'hFF);
    n_cmp++;
    if (o_data !== {56'h0, 8'h1E} || o_head !== 2'b01 || o_err !== 1'b0 || o_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL error_recover: got data=%h head=%b err=%b cnt=%0d, want 1e/01/0/1",
               o_data, o_head, o_err, o_cnt);
    end
  endtask

  task automatic test_ctrl_in_data();
    do_reset();
    drive_word({8{8'h07}}, 8'hFF);
    drive_word({{7{8'hA5}}, 8'hFB}, 8'h01);
    drive_word(64'hCAFEBABE_DEADBEEF, 8'h00);
    drive_word({8{8'h07}}, 8'hFF);
    n_cmp++;
    if (o_data !== {{8{7'h1E}}, 8'h1E} || o_err !== 1'b1) begin
      n_bad++; $display("FAIL ctrl_in_data: got data=%h err=%b, want error block err=1", o_data, o_err);
    end
    drive_word({{7{8'h07}}, 8'hFD}, 8'hFF);
    n_cmp++;
    if (o_data !== {56'h0, 8'h87} || o_head !== 2'b01 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL t0_after_error: got data=%h head=%b err=%b, want %h/01/0",
                        o_data, o_head, o_err, {56'h0, 8'h87});
    end
    drive_word({8{8'h07}}, 8'hFF);
    n_cmp++;
    if (o_data !== {56'h0, 8'h1E} || o_err !== 1'b0) begin
      n_bad++; $display("FAIL c_after_t0: got data=%h err=%b, want idle block err=0", o_data, o_err);
    end
  endtask

  task automatic test_s4();
    do_reset();
    drive_word({8{8'h07}}, 8'hFF);
    drive_word({24'hABCDEF, 8'hFB, 32'h07070707}, 8'h1F);
    n_cmp++;
    if (o_data !== {24'hABCDEF, 32'h0, 8'h33} || o_head !== 2'b01 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL s4_block: got data=%h head=%b err=%b, want %h/01/0",
                        o_data, o_head, o_err, {24'hABCDEF, 32'h0, 8'h33});
    end
  endtask

  task automatic test_gap_and_saturation();
    do_reset();
    drive_word({8{8'h07}}, 8'hFF);
    drive_word({{7{8'h3C}}, 8'hFB}, 8'h01);
    drive_word(64'h0F1E2D3C4B5A6978, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      n_cmp++;
      if (o_vld !== 1'b0 || o_data !== e_data || o_head !== e_head || o_err !== e_err || o_cnt !== e_cnt) begin
        n_bad++; $display("FAIL gap_hold%0d: got vld=%b data=%h head=%b, want vld=0 data=%h head=%b",
                          i, o_vld, o_data, o_head, e_data, e_head);
      end
    end
    drive_word(64'h8877665544332211, 8'h00);
    n_cmp++;
    if (o_vld !== 1'b1 || o_head !== 2'b10 || o_data !== 64'h8877665544332211) begin
      n_bad++; $display("FAIL gap_resume: got vld=%b head=%b data=%h, want 1/10/8877665544332211",
                        o_vld, o_head, o_data);
    end
    drive_word({8'h07, 8'h07, 8'hFD, 40'hAABBCCDDEE}, 8'hE0);
    n_cmp++;
    if (o_data !== e_data || o_head !== 2'b01 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL gap_t5: got data=%h head=%b, want %h/01", o_data, o_head, e_data);
    end
    do_reset();
    drive_word(64'h1, 8'h00);
    for (int i = 0; i < 4; i++) drive_word({$urandom, $urandom}, 8'h55);
    n_cmp++;
    if (o_cnt !== 16'd5 || o_cnt !== e_cnt) begin
      n_bad++; $display("FAIL cnt_five: got %0d want 5", o_cnt);
    end
    n_cmp++;
    if (s_cnt !== 2'd3 || s_cnt !== e_cnt2) begin
      n_bad++; $display("FAIL cnt_saturate: got %0d want 3", s_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_word({8{8'h07}}, 8'hFF);
    drive_word({{7{8'h99}}, 8'hFB}, 8'h01);
    drive_word(64'h1357_9BDF_2468_ACE0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_data !== 64'h0 || o_head !== 2'b00 || o_vld !== 1'b0 || o_err !== 1'b0 || o_cnt !== 16'h0) begin
      n_bad++; $display("FAIL async_reset: got data=%h head=%b vld=%b err=%b cnt=%0d, want all zero",
                        o_data, o_head, o_vld, o_err, o_cnt);
    end
    @(negedge clk);
    vld = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_word({56'h0102030405060F, 8'hFB}, 8'h01);
    n_cmp++;
    if (o_data !== {56'h0102030405060F, 8'h78} || o_head !== 2'b01 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL s0_after_reset: got data=%h head=%b err=%b, want %h/01/0",
                        o_data, o_head, o_err, {56'h0102030405060F, 8'h78});
    end
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [7:0]  c;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) drive_idle();
      else begin
        make_word(d, c);
        drive_word(d, c);
      end
      n_cmp++;
      if (o_vld !== e_vld || o_data !== e_data || o_head !== e_head || o_err !== e_err ||
          o_cnt !== e_cnt || s_cnt !== e_cnt2) begin
        n_bad++;
        $display("FAIL random%0d: got vld=%b data=%h head=%b err=%b cnt=%0d/%0d, want %b %h %b %b %0d/%0d",
                 i, o_vld, o_data, o_head, o_err, o_cnt, s_cnt,
                 e_vld, e_data, e_head, e_err, e_cnt, e_cnt2);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_error_first();
    test_ctrl_in_data();
    test_s4();
    test_gap_and_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
